// File: rtl/dcache_stall_ctrl.sv
// Data-cache miss/stall sequencer: read-miss block refill, write-through stores, one-cycle completion.
// Optional performance counters enabled by defining DCACHE_PERF_CNT_EN.
module dcache_stall_ctrl #(
    parameter int BLOCK_WORDS = 4,
    parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             hit,
    input  logic             mem_ready,
    output logic             stall,
    output logic             mem_rd_req,
    output logic             mem_wr_req,
    output logic             refill_en,
    output logic [IDX_W-1:0] refill_idx,
    output logic [31:0]      miss_cnt,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_MISS,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        stall      = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        refill_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Stall combinationally in the detect cycle so the PC never advances past the access.
                stall = MemWrite | (MemRead & ~hit);
                idx_d = '0;
                if (MemWrite) begin
                    state_d = S_WRITE;
                end else if (MemRead && !hit) begin
                    state_d = S_READ_MISS;
                end
            end
            S_READ_MISS: begin
                stall      = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_ready) begin
                    refill_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                stall      = 1'b1;
                mem_wr_req = 1'b1;
                if (mem_ready) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                // Completion cycle: pipeline runs once, requests are not re-evaluated here.
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign refill_idx = idx_q;

`ifdef DCACHE_PERF_CNT_EN
    logic        miss_start;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        miss_start  = (state_q == S_IDLE) && (state_d == S_READ_MISS);
        miss_cnt_d  = miss_cnt_q + {31'd0, miss_start};
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign miss_cnt  = miss_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign miss_cnt  = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Self-checking bench for dcache_stall_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dcache_stall_ctrl;

    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst, MemRead, MemWrite, hit, mem_ready;
    logic        stall, mem_rd_req, mem_wr_req, refill_en;
    logic [1:0]  refill_idx;
    logic [31:0] miss_cnt, stall_cnt;

    dcache_stall_ctrl #(.BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .hit(hit),
        .mem_ready(mem_ready), .stall(stall), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .refill_en(refill_en), .refill_idx(refill_idx), .miss_cnt(miss_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: words still owed by memory, outstanding store, pending completion cycle.
    int          pend_words = 0;
    bit          pend_wr = 0, completing = 0, model_valid = 0;
    logic [31:0] exp_miss = 0, exp_stallc = 0;

    int n_stall, n_rd, n_wr;
    int idx_list[$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic wr, input logic h, input logic rdy);
        logic busy, e_stall, e_en;
        logic [1:0] e_idx;
        logic [31:0] e_m, e_s;
        rst = r; MemRead = rd; MemWrite = wr; hit = h; mem_ready = rdy;
        #1;
        busy    = (pend_words > 0);
        e_en    = busy && rdy;
        e_idx   = busy ? 2'(BW - pend_words) : 2'd0;
        e_stall = (busy || pend_wr) ? 1'b1 : (completing ? 1'b0 : (wr | (rd & ~h)));
`ifdef DCACHE_PERF_CNT_EN
        e_m = exp_miss; e_s = exp_stallc;
`else
        e_m = 32'd0; e_s = 32'd0;
`endif
        if (model_valid) begin
            chk1("stall", stall, e_stall);
            chk1("mem_rd_req", mem_rd_req, busy);
            chk1("mem_wr_req", mem_wr_req, pend_wr);
            chk1("refill_en", refill_en, e_en);
            chk32("refill_idx", {30'd0, refill_idx}, {30'd0, e_idx});
            chk32("miss_cnt", miss_cnt, e_m);
            chk32("stall_cnt", stall_cnt, e_s);
        end
        if (stall === 1'b1) n_stall++;
        if (mem_rd_req === 1'b1) n_rd++;
        if (mem_wr_req === 1'b1) n_wr++;
        if (refill_en === 1'b1) idx_list.push_back(int'(refill_idx));
        @(posedge clk);
        if (r) begin
            pend_words = 0; pend_wr = 0; completing = 0;
            exp_miss = 0; exp_stallc = 0; model_valid = 1;
        end else begin
            exp_stallc += {31'd0, e_stall};
            if (completing) begin
                completing = 0;
            end else if (busy) begin
                if (rdy) begin
                    pend_words--;
                    if (pend_words == 0) completing = 1;
                end
            end else if (pend_wr) begin
                if (rdy) begin
                    pend_wr = 0; completing = 1;
                end
            end else if (wr) begin
                pend_wr = 1;
            end else if (rd && !h) begin
                pend_words = BW;
                exp_miss += 1;
            end
        end
        @(negedge clk);
    endtask

    // One access: detect cycle, service cycles with ready every 'period' cycles, completion, idle.
    task automatic run_access(input logic rd, input logic wr, input logic h, input int period);
        int k;
        n_stall = 0; n_rd = 0; n_wr = 0;
        idx_list.delete();
        cyc(0, rd, wr, h, 1'b1);
        k = 0;
        while ((pend_words > 0 || pend_wr) && k < 200) begin
            cyc(0, rd, wr, h, ((k % period) == period - 1));
            k++;
        end
        chk1("service_bounded", (k < 200), 1'b1);
        cyc(0, rd, wr, h, 1'b1);
        cyc(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_idx_seq(input string tag);
        chk32({tag, "_nwords"}, idx_list.size(), BW);
        for (int i = 0; i < idx_list.size(); i++) chk32({tag, "_idx"}, idx_list[i], i);
    endtask

    initial begin
        @(negedge clk);
        // Reset while a miss is presented: stall follows the IDLE equation.
        cyc(1, 1, 0, 0, 0);
        chk1("rst_stall", stall, 1'b1);
        chk1("rst_rd_req", mem_rd_req, 1'b0);
        chk1("rst_wr_req", mem_wr_req, 1'b0);
        chk1("rst_refill_en", refill_en, 1'b0);
        chk32("rst_refill_idx", {30'd0, refill_idx}, 32'd0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk32("rst_miss_cnt", miss_cnt, 32'd0);
        chk32("rst_stall_cnt", stall_cnt, 32'd0);

        run_access(1, 0, 0, 1);
        chk32("miss_fast_stalls", n_stall, 5);
        chk32("miss_fast_rdreq", n_rd, 4);
        chk_idx_seq("miss_fast");
`ifdef DCACHE_PERF_CNT_EN
        chk32("miss_fast_misscnt", miss_cnt, 32'd1);
        chk32("miss_fast_stallcnt", stall_cnt, 32'd5);
`endif

        run_access(1, 0, 0, 3);
        chk32("miss_slow_stalls", n_stall, 13);
        chk32("miss_slow_rdreq", n_rd, 12);
        chk_idx_seq("miss_slow");

        run_access(0, 1, 1, 4);
        chk32("store_wrreq", n_wr, 4);
        chk32("store_stalls", n_stall, 5);
        chk32("store_refills", idx_list.size(), 0);

        run_access(1, 1, 0, 1);
        chk32("both_rdreq", n_rd, 0);
        chk32("both_wrreq", n_wr, 1);
        chk32("both_stalls", n_stall, 2);

        // Reset on the second refill word, then a fresh miss.
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        rst = 0; MemRead = 0; #1;
        chk32("abort_idx", {30'd0, refill_idx}, 32'd0);
        chk1("abort_rdreq", mem_rd_req, 1'b0);
        @(negedge clk);
        cyc(0, 0, 0, 0, 0);
        run_access(1, 0, 0, 1);
        chk32("restart_stalls", n_stall, 5);
        chk_idx_seq("restart");

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
